// File: rtl/alu_multicycle_if.sv
// Handshake bundle between pipeline control and the execute-stage ALU.
// Master is the pipeline side; slave is the ALU.
interface alu_multicycle_if #(
  parameter int DATA_W = 64
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        alu_control;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic              out_valid;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              busy;

  modport master (
    output flush, in_valid, alu_control,
    output operand_a, operand_b,
    input  in_ready, out_valid, result,
    input  zero, busy
  );

  modport slave (
    input  flush, in_valid, alu_control,
    input  operand_a, operand_b,
    output in_ready, out_valid, result,
    output zero, busy
  );
endinterface

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: registered single-cycle ops plus an
// iterative radix-2 shift-add multiplier that stalls the pipe.
module alu_multicycle #(
  parameter int DATA_W  = 64,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input logic             clk,
  input logic             rst,
  alu_multicycle_if.slave bus
);
  localparam int CNT_W = SHAMT_W + 1;

  typedef enum logic [0:0] {
    S_IDLE,
    S_MUL
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              r_out_valid;

  logic              w_ready;
  logic              w_accept;
  logic              w_is_mul;
  logic              w_mul_last;
  logic [SHAMT_W-1:0] w_shamt;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_acc_nxt;

  assign w_ready    = (r_state == S_IDLE) & ~bus.flush;
  assign w_accept   = bus.in_valid & w_ready;
  assign w_is_mul   = (bus.alu_control == 4'd8);
  assign w_mul_last = (r_state == S_MUL) & (r_cnt == CNT_W'(1));
  assign w_shamt    = bus.operand_b[SHAMT_W-1:0];
  assign w_acc_nxt  = r_mplier[0] ? r_acc + r_mcand : r_acc;

  always_comb begin
    w_alu = '0;
    case (bus.alu_control)
      4'd0: w_alu = bus.operand_a & bus.operand_b;
      4'd1: w_alu = bus.operand_a | bus.operand_b;
      4'd2: w_alu = bus.operand_a + bus.operand_b;
      4'd3: w_alu = bus.operand_a << w_shamt;
      4'd4: w_alu = bus.operand_a >> w_shamt;
      4'd6: w_alu = bus.operand_a - bus.operand_b;
      4'd7: w_alu = {{(DATA_W-1){1'b0}},
                     $signed(bus.operand_a) < $signed(bus.operand_b)};
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept && w_is_mul) w_state_nxt = S_MUL;
        S_MUL:  if (w_mul_last) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (bus.flush) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        if (w_is_mul) begin
          r_mcand  <= bus.operand_a;
          r_mplier <= bus.operand_b;
          r_acc    <= '0;
          r_cnt    <= CNT_W'(DATA_W);
        end else begin
          r_result    <= w_alu;
          r_zero      <= (w_alu == '0);
          r_out_valid <= 1'b1;
        end
      end else if (r_state == S_MUL) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CNT_W'(1);
        // final step folds in the last partial product
        if (w_mul_last) begin
          r_result    <= w_acc_nxt;
          r_zero      <= (w_acc_nxt == '0);
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.busy      = (r_state == S_MUL);
endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: directed vectors push
// expected results; a negedge monitor pops on each out_valid.
module tb_alu_multicycle;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_push = 0;
  int   n_seen = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
  } exp_t;

  exp_t q[$];

  alu_multicycle_if #(.DATA_W(W)) bus();

  alu_multicycle #(.DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      exp_t e;
      n_seen++;
      n_checks++;
      if (q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_out_valid actual result=%h required no pulse",
                 bus.result);
      end else begin
        e = q.pop_front();
        if (bus.result !== e.res || bus.zero !== e.z) begin
          n_errors++;
          $display("FAIL result actual=%h/%b required=%h/%b",
                   bus.result, bus.zero, e.res, e.z);
        end
      end
    end
  end

  task automatic drive(input logic [3:0] c, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    bus.alu_control = c;
    bus.operand_a   = a;
    bus.operand_b   = b;
  endtask

  // caller is at posedge+1; accept happens at the next posedge
  task automatic send(input logic [3:0] c, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] er,
                      input logic pushit);
    drive(c, a, b);
    bus.in_valid = 1'b1;
    if (pushit) begin
      q.push_back('{res: er, z: (er == '0)});
      n_push++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int busy_cnt;
    logic rdy_bad;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    drive(4'd0, '0, '0);
    cycles(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_result", bus.result, '0);
    chk("rst_zero", W'(bus.zero), W'(1));
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_in_ready", W'(bus.in_ready), W'(1));
    chk("rst_busy", W'(bus.busy), W'(0));
    @(posedge clk); #1;

    send(4'd2, 64'd5, 64'd7, 64'd12, 1'b1);
    send(4'd6, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    send(4'd7, '1, 64'd1, 64'd1, 1'b1);
    send(4'd3, 64'd1, 64'd65, 64'd2, 1'b1);
    send(4'd6, 64'd9, 64'd9, 64'd0, 1'b1);
    send(4'd0, 64'hF0F0, 64'hFF00, 64'hF000, 1'b1);
    send(4'd1, 64'hF0F0, 64'h0F0F, 64'hFFFF, 1'b1);
    send(4'd4, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1'b1);
    send(4'd7, 64'd1, '1, 64'd0, 1'b1);
    send(4'd5, 64'd3, 64'd4, 64'd0, 1'b1);
    send(4'd15, 64'd3, 64'd4, 64'd0, 1'b1);
    cycles(2);

    // MUL 7 * -3 with an ADD held on in_valid throughout
    send(4'd8, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
         64'hFFFF_FFFF_FFFF_FFEB, 1'b1);
    drive(4'd2, 64'd100, 64'd1);
    bus.in_valid = 1'b1;
    busy_cnt = 0;
    rdy_bad = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) break;
      busy_cnt++;
      if (bus.in_ready !== 1'b0) rdy_bad = 1'b1;
    end
    chk("mul_busy_cycles", W'(busy_cnt), W'(64));
    chk("mul_in_ready_low", W'(rdy_bad), W'(0));
    chk("mul_done_in_ready", W'(bus.in_ready), W'(1));
    drive(4'd2, 64'd20, 64'd22);
    q.push_back('{res: 64'd42, z: 1'b0});
    n_push++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cycles(3);

    // flush at cycle 10 of a MUL
    send(4'd8, 64'd3, 64'd4, '0, 1'b0);
    cycles(9);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", W'(bus.busy), W'(0));
    chk("flush_result", bus.result, 64'd42);
    @(posedge clk); #1;

    // flush with in_valid in IDLE: not accepted
    drive(4'd2, 64'd5, 64'd5);
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", W'(bus.in_ready), W'(0));
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    cycles(80);
    chk("flush_result_hold", bus.result, 64'd42);

    // reset at cycle 20 of a MUL
    send(4'd8, 64'd7, 64'd7, '0, 1'b0);
    cycles(19);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_result", bus.result, '0);
    chk("mrst_zero", W'(bus.zero), W'(1));
    chk("mrst_in_ready", W'(bus.in_ready), W'(1));
    chk("mrst_busy", W'(bus.busy), W'(0));
    @(posedge clk); #1;

    send(4'd2, 64'd1, 64'd1, 64'd2, 1'b1);
    send(4'd2, 64'd2, 64'd2, 64'd4, 1'b1);
    send(4'd2, 64'd3, 64'd3, 64'd6, 1'b1);
    send(4'd2, '1, 64'd1, 64'd0, 1'b1);
    cycles(5);

    chk("queue_drained", W'(q.size()), W'(0));
    chk("pulse_count", W'(n_seen), W'(n_push));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
